// File: rtl/udp_cmd_parser_if.sv
// Bundled RX byte stream, register command bus and TX reply stream seen by udp_cmd_parser.
// slave = the parser side, master = the surrounding deframer / cmd router / TX builder.
interface udp_cmd_parser_if #(parameter int ADDR_BITS = 26);
    logic [7:0]           i_rx_data;
    logic                 i_rx_valid;
    logic                 i_rx_eop;
    logic                 o_rx_ready;
    logic                 o_cmd_valid;
    logic                 o_cmd_wr;
    logic [ADDR_BITS-1:0] o_cmd_addr;
    logic [31:0]          o_cmd_wdata;
    logic                 i_cmd_ack;
    logic [31:0]          i_cmd_rdata;
    logic [7:0]           o_tx_data;
    logic                 o_tx_valid;
    logic                 o_tx_sop;
    logic                 o_tx_eop;
    logic                 i_tx_ready;

    modport slave (
        input  i_rx_data, i_rx_valid, i_rx_eop, i_cmd_ack, i_cmd_rdata, i_tx_ready,
        output o_rx_ready, o_cmd_valid, o_cmd_wr, o_cmd_addr, o_cmd_wdata,
               o_tx_data, o_tx_valid, o_tx_sop, o_tx_eop
    );

    modport master (
        output i_rx_data, i_rx_valid, i_rx_eop, i_cmd_ack, i_cmd_rdata, i_tx_ready,
        input  o_rx_ready, o_cmd_valid, o_cmd_wr, o_cmd_addr, o_cmd_wdata,
               o_tx_data, o_tx_valid, o_tx_sop, o_tx_eop
    );
endinterface

// File: rtl/udp_cmd_parser.sv
// UDP command parser: decodes a command payload, issues one register transaction,
// then returns a fixed 13-byte reply {seq, code, addr, data}.
package udp_cmd_pkg;
    localparam int         UDP_CMD_ACK_TIMEOUT_CLKS = 512;
    localparam int         UDP_CMD_ADDR_BITS        = 26;
    localparam logic [7:0] REG_WRITE_REQ            = 8'h00;
    localparam logic [7:0] REG_READ_REQ             = 8'h01;
    localparam logic [7:0] MSG_ACK                  = 8'hF0;
    localparam logic [7:0] MSG_NACK                 = 8'hF1;
    localparam logic [7:0] MSG_UNKNOWN              = 8'hFF;
endpackage

module udp_cmd_parser
    import udp_cmd_pkg::*;
#(
    parameter int ACK_TIMEOUT_CLKS = UDP_CMD_ACK_TIMEOUT_CLKS,
    parameter int ADDR_BITS        = UDP_CMD_ADDR_BITS
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_srst,
    udp_cmd_parser_if.slave   bus
);
    localparam int                TMO_W    = $clog2(ACK_TIMEOUT_CLKS);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(ACK_TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {S_RX, S_CHECK, S_CMD, S_RESP} state_t;

    state_t               state, next_state;
    logic                 rx_ready_q;
    logic [3:0]           rx_cnt, tx_idx;
    logic [31:0]          seq, addr, wdata, resp_data;
    logic [7:0]           msg_id, code;
    logic [TMO_W-1:0]     tmo_cnt;
    logic                 cmd_wr;
    logic [ADDR_BITS-1:0] cmd_addr;
    logic [31:0]          cmd_wdata;
    logic                 rx_fire, tx_fire, pkt_drop, id_ok, addr_ok, tmo_hit;
    logic [12:0][7:0]     reply_b;

    assign rx_fire  = bus.i_rx_valid && rx_ready_q && (state == S_RX);
    assign tx_fire  = bus.i_tx_ready && (state == S_RESP);
    // rx_cnt is the index of the current byte, so the packet length is rx_cnt+1
    assign pkt_drop = (rx_cnt < 4'd8) || ((msg_id == REG_WRITE_REQ) && (rx_cnt < 4'd12));
    assign id_ok    = (msg_id == REG_WRITE_REQ) || (msg_id == REG_READ_REQ);
    assign addr_ok  = (addr >> ADDR_BITS) == 32'd0;
    assign tmo_hit  = (tmo_cnt == TMO_LAST);
    assign reply_b  = {seq, code, addr, resp_data};

    always_comb begin
        next_state = state;
        case (state)
            S_RX:    if (rx_fire && bus.i_rx_eop && !pkt_drop) next_state = S_CHECK;
            S_CHECK: next_state = (id_ok && addr_ok) ? S_CMD : S_RESP;
            S_CMD:   if (bus.i_cmd_ack || tmo_hit) next_state = S_RESP;
            S_RESP:  if (tx_fire && (tx_idx == 4'd12)) next_state = S_RX;
            default: next_state = S_RX;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_srst) begin
            state      <= S_RX;
            rx_ready_q <= 1'b0;
            rx_cnt     <= '0;
            tx_idx     <= '0;
            tmo_cnt    <= '0;
            seq        <= '0;
            msg_id     <= '0;
            addr       <= '0;
            wdata      <= '0;
            code       <= '0;
            resp_data  <= '0;
            cmd_wr     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
        end else begin
            state      <= next_state;
            rx_ready_q <= (next_state == S_RX);
            case (state)
                S_RX: if (rx_fire) begin
                    if (rx_cnt <= 4'd3)       seq    <= {seq[23:0], bus.i_rx_data};
                    else if (rx_cnt == 4'd4)  msg_id <= bus.i_rx_data;
                    else if (rx_cnt <= 4'd8)  addr   <= {addr[23:0], bus.i_rx_data};
                    else if (rx_cnt <= 4'd12) wdata  <= {wdata[23:0], bus.i_rx_data};
                    if (bus.i_rx_eop)         rx_cnt <= '0;
                    else if (rx_cnt < 4'd13)  rx_cnt <= rx_cnt + 4'd1;
                end
                S_CHECK: begin
                    resp_data <= '0;
                    tmo_cnt   <= '0;
                    if (!id_ok)        code <= MSG_UNKNOWN;
                    else if (!addr_ok) code <= MSG_NACK;
                    else begin
                        cmd_wr    <= (msg_id == REG_WRITE_REQ);
                        cmd_addr  <= addr[ADDR_BITS-1:0];
                        cmd_wdata <= wdata;
                    end
                end
                S_CMD: begin
                    // ack is checked first so it wins over a coincident timeout
                    if (bus.i_cmd_ack) begin
                        code      <= MSG_ACK;
                        resp_data <= cmd_wr ? cmd_wdata : bus.i_cmd_rdata;
                    end else if (tmo_hit) begin
                        code      <= MSG_NACK;
                        resp_data <= '0;
                    end else begin
                        tmo_cnt   <= tmo_cnt + 1'b1;
                    end
                end
                S_RESP: if (tx_fire) tx_idx <= (tx_idx == 4'd12) ? 4'd0 : tx_idx + 4'd1;
                default: ;
            endcase
        end
    end

    assign bus.o_rx_ready  = rx_ready_q;
    assign bus.o_cmd_valid = (state == S_CMD);
    assign bus.o_cmd_wr    = cmd_wr;
    assign bus.o_cmd_addr  = cmd_addr;
    assign bus.o_cmd_wdata = cmd_wdata;
    assign bus.o_tx_valid  = (state == S_RESP);
    assign bus.o_tx_sop    = (state == S_RESP) && (tx_idx == 4'd0);
    assign bus.o_tx_eop    = (state == S_RESP) && (tx_idx == 4'd12);
    assign bus.o_tx_data   = (state == S_RESP) ? reply_b[4'd12 - tx_idx] : 8'h00;
endmodule

// File: tb/tb_udp_cmd_parser.sv
// Directed bench for udp_cmd_parser: write/read/timeout/reject/drop/backpressure/reset scenarios.
module tb_udp_cmd_parser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    udp_cmd_parser_if #(.ADDR_BITS(26)) bus ();
    udp_cmd_parser dut (.i_sys_clk(clk), .i_sys_srst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    logic [7:0] pkt [0:15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pkt(input logic [31:0] s, input logic [7:0] id,
                            input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            pkt[i]     = 8'(s >> (24 - 8 * i));
            pkt[5 + i] = 8'(a >> (24 - 8 * i));
            pkt[9 + i] = 8'(w >> (24 - 8 * i));
        end
        pkt[4] = id;
        for (int i = 13; i < 16; i++) pkt[i] = 8'hA5;
    endtask

    task automatic send_pkt(input int len);
        int g;
        for (int i = 0; i < len; i++) begin
            bus.i_rx_valid = 1'b1;
            bus.i_rx_data  = pkt[i];
            bus.i_rx_eop   = (i == len - 1);
            g = 0;
            while (bus.o_rx_ready !== 1'b1 && g < 50) begin tick(); g++; end
            if (g >= 50) begin
                total++; bad++;
                $display("FAIL rx_ready_wait: byte %0d not accepted within 50 clocks", i);
            end
            tick();
        end
        bus.i_rx_valid = 1'b0;
        bus.i_rx_eop   = 1'b0;
    endtask

    // Collects one reply; records framing errors, stall instability, rx_ready and cmd_valid activity.
    task automatic get_reply(input bit bp, output logic [103:0] rep, output int frame_err,
                             output int unstable, output int rxr_hi, output int cmd_hi);
        int n, g;
        logic stalled;
        logic [7:0] pd;
        n = 0; g = 0; stalled = 1'b0; pd = '0;
        rep = '0; frame_err = 0; unstable = 0; rxr_hi = 0; cmd_hi = 0;
        while (n < 13 && g < 2000) begin
            bus.i_tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled && (bus.o_tx_valid !== 1'b1 || bus.o_tx_data !== pd)) unstable++;
            if (bus.o_rx_ready === 1'b1) rxr_hi++;
            if (bus.o_cmd_valid === 1'b1) cmd_hi++;
            if (bus.o_tx_valid === 1'b1 && bus.i_tx_ready) begin
                rep = {rep[95:0], bus.o_tx_data};
                if (bus.o_tx_sop !== (n == 0))  frame_err++;
                if (bus.o_tx_eop !== (n == 12)) frame_err++;
                n++;
                stalled = 1'b0;
            end else begin
                stalled = (bus.o_tx_valid === 1'b1);
                pd      = bus.o_tx_data;
            end
            tick();
            g++;
        end
        bus.i_tx_ready = 1'b0;
        if (n < 13) begin
            total++; bad++;
            $display("FAIL reply_wait: got %0d of 13 bytes", n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        total++;
        if ({bus.o_rx_ready, bus.o_cmd_valid, bus.o_cmd_wr, bus.o_cmd_addr, bus.o_cmd_wdata,
             bus.o_tx_valid, bus.o_tx_sop, bus.o_tx_eop, bus.o_tx_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: rx_ready=%b cmd_valid=%b tx_valid=%b addr=%h want all 0",
                     bus.o_rx_ready, bus.o_cmd_valid, bus.o_tx_valid, bus.o_cmd_addr);
        end
        rst = 1'b0;
        tick();
        total++;
        if (bus.o_rx_ready !== 1'b1) begin
            bad++; $display("FAIL reset_rx_ready: got %b want 1", bus.o_rx_ready);
        end
    endtask

    task automatic test_write();
        logic [103:0] rep;
        int fe, us, rh, ch, hold_bad;
        load_pkt(32'h0000_0007, 8'h00, 32'h0001_0004, 32'hDEAD_BEEF);
        send_pkt(13);
        total++;
        if (bus.o_cmd_valid !== 1'b0 || bus.o_rx_ready !== 1'b0) begin
            bad++; $display("FAIL wr_check_cycle: cmd_valid=%b rx_ready=%b want 0 0",
                            bus.o_cmd_valid, bus.o_rx_ready);
        end
        tick();
        total++;
        if ({bus.o_cmd_valid, bus.o_cmd_wr, bus.o_cmd_addr, bus.o_cmd_wdata} !==
            {1'b1, 1'b1, 26'h001_0004, 32'hDEAD_BEEF}) begin
            bad++; $display("FAIL wr_cmd: valid=%b wr=%b addr=%h wdata=%h want 1 1 0010004 deadbeef",
                            bus.o_cmd_valid, bus.o_cmd_wr, bus.o_cmd_addr, bus.o_cmd_wdata);
        end
        hold_bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.o_cmd_valid !== 1'b1 || bus.o_cmd_addr !== 26'h001_0004 ||
                bus.o_cmd_wdata !== 32'hDEAD_BEEF) hold_bad++;
        end
        total++;
        if (hold_bad != 0) begin bad++; $display("FAIL wr_cmd_hold: %0d unstable cycles want 0", hold_bad); end
        bus.i_cmd_rdata = 32'hFFFF_FFFF;
        bus.i_cmd_ack   = 1'b1;
        tick();
        bus.i_cmd_ack   = 1'b0;
        total++;
        if ({bus.o_cmd_valid, bus.o_tx_valid, bus.o_tx_sop} !== 3'b011) begin
            bad++; $display("FAIL wr_ack_latency: cmd_valid=%b tx_valid=%b sop=%b want 0 1 1",
                            bus.o_cmd_valid, bus.o_tx_valid, bus.o_tx_sop);
        end
        get_reply(1'b0, rep, fe, us, rh, ch);
        total++;
        if (rep !== 104'h00000007_F0_00010004_DEADBEEF || fe != 0) begin
            bad++; $display("FAIL wr_reply: got %h frame_err=%0d want 00000007f000010004deadbeef 0", rep, fe);
        end
        total++;
        if (bus.o_rx_ready !== 1'b1) begin bad++; $display("FAIL wr_rx_ready_after: got %b want 1", bus.o_rx_ready); end
    endtask

    task automatic test_read();
        logic [103:0] rep;
        int fe, us, rh, ch;
        load_pkt(32'h0000_0011, 8'h01, 32'h0000_0010, 32'h0);
        send_pkt(9);
        tick();
        total++;
        if ({bus.o_cmd_valid, bus.o_cmd_wr, bus.o_cmd_addr} !== {1'b1, 1'b0, 26'h10}) begin
            bad++; $display("FAIL rd_cmd: valid=%b wr=%b addr=%h want 1 0 0000010",
                            bus.o_cmd_valid, bus.o_cmd_wr, bus.o_cmd_addr);
        end
        bus.i_cmd_rdata = 32'h1234_5678;
        bus.i_cmd_ack   = 1'b1;
        tick();
        bus.i_cmd_ack   = 1'b0;
        bus.i_cmd_rdata = 32'hBAD0_BAD0;
        get_reply(1'b0, rep, fe, us, rh, ch);
        total++;
        if (rep !== 104'h00000011_F0_00000010_12345678 || fe != 0) begin
            bad++; $display("FAIL rd_reply: got %h frame_err=%0d want 00000011f00000001012345678 0", rep, fe);
        end
    endtask

    task automatic test_timeout();
        logic [103:0] rep;
        int fe, us, rh, ch, hi;
        load_pkt(32'h0000_0022, 8'h01, 32'h0000_0020, 32'h0);
        send_pkt(9);
        hi = 0;
        for (int g = 0; g < 700; g++) begin
            tick();
            if (bus.o_cmd_valid === 1'b1) hi++;
            else if (hi > 0) break;
        end
        total++;
        if (hi != 512) begin bad++; $display("FAIL tmo_cmd_len: cmd_valid high %0d clocks want 512", hi); end
        total++;
        if (bus.o_tx_valid !== 1'b1) begin bad++; $display("FAIL tmo_tx_valid: got %b want 1", bus.o_tx_valid); end
        get_reply(1'b0, rep, fe, us, rh, ch);
        total++;
        if (rep !== 104'h00000022_F1_00000020_00000000 || fe != 0) begin
            bad++; $display("FAIL tmo_reply: got %h frame_err=%0d want 00000022f10000002000000000 0", rep, fe);
        end
    endtask

    task automatic test_bad_id();
        logic [103:0] rep;
        int fe, us, rh, ch;
        load_pkt(32'h0000_0033, 8'h05, 32'h0000_0040, 32'h0);
        send_pkt(9);
        total++;
        if (bus.o_tx_valid !== 1'b0) begin bad++; $display("FAIL badid_early_tx: got %b want 0", bus.o_tx_valid); end
        tick();
        total++;
        if ({bus.o_tx_valid, bus.o_cmd_valid} !== 2'b10) begin
            bad++; $display("FAIL badid_latency: tx_valid=%b cmd_valid=%b want 1 0", bus.o_tx_valid, bus.o_cmd_valid);
        end
        get_reply(1'b0, rep, fe, us, rh, ch);
        total++;
        if (rep !== 104'h00000033_FF_00000040_00000000 || fe != 0 || ch != 0) begin
            bad++; $display("FAIL badid_reply: got %h frame_err=%0d cmd_hi=%0d want 00000033ff0000004000000000 0 0",
                            rep, fe, ch);
        end
    endtask

    task automatic test_bad_addr();
        logic [103:0] rep;
        int fe, us, rh, ch;
        load_pkt(32'h0000_0044, 8'h00, 32'h0400_0000, 32'h1122_3344);
        send_pkt(13);
        tick();
        total++;
        if ({bus.o_tx_valid, bus.o_cmd_valid} !== 2'b10) begin
            bad++; $display("FAIL badaddr_latency: tx_valid=%b cmd_valid=%b want 1 0", bus.o_tx_valid, bus.o_cmd_valid);
        end
        get_reply(1'b0, rep, fe, us, rh, ch);
        total++;
        if (rep !== 104'h00000044_F1_04000000_00000000 || fe != 0 || ch != 0) begin
            bad++; $display("FAIL badaddr_reply: got %h frame_err=%0d cmd_hi=%0d want 00000044f10400000000000000 0 0",
                            rep, fe, ch);
        end
    endtask

    task automatic test_short();
        int viol;
        viol = 0;
        load_pkt(32'h0000_0066, 8'h01, 32'h0000_0001, 32'h0);
        send_pkt(7);
        for (int i = 0; i < 12; i++) begin
            bus.i_cmd_ack = (i == 5);
            if (bus.o_cmd_valid !== 1'b0 || bus.o_tx_valid !== 1'b0 || bus.o_rx_ready !== 1'b1) viol++;
            tick();
        end
        bus.i_cmd_ack = 1'b0;
        load_pkt(32'h0000_0067, 8'h00, 32'h0000_0002, 32'h5555_AAAA);
        send_pkt(10);
        for (int i = 0; i < 12; i++) begin
            if (bus.o_cmd_valid !== 1'b0 || bus.o_tx_valid !== 1'b0 || bus.o_rx_ready !== 1'b1) viol++;
            tick();
        end
        total++;
        if (viol != 0) begin bad++; $display("FAIL short_drop: %0d cycles with activity want 0", viol); end
    endtask

    task automatic test_backpressure();
        logic [103:0] rep;
        int fe, us, rh, ch, g;
        load_pkt(32'h0000_0055, 8'h00, 32'h0000_0ABC, 32'hCAFE_F00D);
        send_pkt(15);
        g = 0;
        while (bus.o_cmd_valid !== 1'b1 && g < 20) begin tick(); g++; end
        total++;
        if (bus.o_cmd_wdata !== 32'hCAFE_F00D || bus.o_cmd_valid !== 1'b1) begin
            bad++; $display("FAIL bp_cmd: valid=%b wdata=%h want 1 cafef00d", bus.o_cmd_valid, bus.o_cmd_wdata);
        end
        bus.i_cmd_ack = 1'b1;
        tick();
        bus.i_cmd_ack = 1'b0;
        get_reply(1'b1, rep, fe, us, rh, ch);
        total++;
        if (rep !== 104'h00000055_F0_00000ABC_CAFEF00D || fe != 0 || us != 0 || rh != 0) begin
            bad++; $display("FAIL bp_reply: got %h frame_err=%0d unstable=%0d rx_ready_hi=%0d want 00000055f000000abccafef00d 0 0 0",
                            rep, fe, us, rh);
        end
        total++;
        if (bus.o_rx_ready !== 1'b1) begin bad++; $display("FAIL bp_rx_ready_after: got %b want 1", bus.o_rx_ready); end
    endtask

    task automatic test_reset_mid();
        logic [103:0] rep;
        int fe, us, rh, ch, g, leak;
        load_pkt(32'h0000_0077, 8'h01, 32'h0000_0030, 32'h0);
        send_pkt(9);
        tick();
        rst = 1'b1;
        tick();
        total++;
        if ({bus.o_rx_ready, bus.o_cmd_valid, bus.o_cmd_wr, bus.o_cmd_addr, bus.o_cmd_wdata,
             bus.o_tx_valid, bus.o_tx_sop, bus.o_tx_eop, bus.o_tx_data} !== '0) begin
            bad++; $display("FAIL rst_mid_cmd: cmd_valid=%b addr=%h rx_ready=%b want all 0",
                            bus.o_cmd_valid, bus.o_cmd_addr, bus.o_rx_ready);
        end
        rst = 1'b0;
        tick();
        load_pkt(32'h0000_0078, 8'h00, 32'h0000_0050, 32'hA1B2_C3D4);
        send_pkt(13);
        tick();
        bus.i_cmd_ack = 1'b1;
        tick();
        bus.i_cmd_ack  = 1'b0;
        bus.i_tx_ready = 1'b1;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        total++;
        if ({bus.o_rx_ready, bus.o_cmd_valid, bus.o_cmd_wr, bus.o_cmd_addr, bus.o_cmd_wdata,
             bus.o_tx_valid, bus.o_tx_sop, bus.o_tx_eop, bus.o_tx_data} !== '0) begin
            bad++; $display("FAIL rst_mid_resp: tx_valid=%b data=%h wr=%b wdata=%h want all 0",
                            bus.o_tx_valid, bus.o_tx_data, bus.o_cmd_wr, bus.o_cmd_wdata);
        end
        rst = 1'b0;
        leak = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (bus.o_tx_valid !== 1'b0) leak++; end
        bus.i_tx_ready = 1'b0;
        total++;
        if (leak != 0) begin bad++; $display("FAIL rst_partial_reply: %0d tx_valid cycles want 0", leak); end
        load_pkt(32'h0000_0079, 8'h01, 32'h0000_0060, 32'h0);
        send_pkt(9);
        g = 0;
        while (bus.o_cmd_valid !== 1'b1 && g < 20) begin tick(); g++; end
        bus.i_cmd_rdata = 32'h0BAD_F00D;
        bus.i_cmd_ack   = 1'b1;
        tick();
        bus.i_cmd_ack   = 1'b0;
        get_reply(1'b0, rep, fe, us, rh, ch);
        total++;
        if (rep !== 104'h00000079_F0_00000060_0BADF00D || fe != 0) begin
            bad++; $display("FAIL rst_recover_reply: got %h frame_err=%0d want 00000079f0000000600badf00d 0", rep, fe);
        end
    endtask

    initial begin
        bus.i_rx_data   = '0;
        bus.i_rx_valid  = 1'b0;
        bus.i_rx_eop    = 1'b0;
        bus.i_cmd_ack   = 1'b0;
        bus.i_cmd_rdata = '0;
        bus.i_tx_ready  = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_bad_id();
        test_bad_addr();
        test_short();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
